// File: rtl/msx_pkg.sv
// Shared types and constants for the MSX mouse port: phase encoding,
// saturation limit, joystick idle pattern and the accumulator clamp.
package msx_pkg;
    typedef enum logic [1:0] {P0, P1, P2, P3} mouse_phase_t;

    localparam int         MOUSE_SAT = 127;
    localparam logic [5:0] JOY_IDLE  = 6'h3F;
    localparam int         NUM_AXES  = 2;
    localparam int         DELTA_W   = 9;
    localparam int         ACC_W     = 8;

    // Symmetric clamp: -128 is never produced, so negating a snapshot never overflows.
    function automatic logic [ACC_W-1:0] sat_acc(input logic signed [9:0] v);
        logic signed [9:0] lim;
        lim = 10'(MOUSE_SAT);
        if (v > lim)       sat_acc = lim[ACC_W-1:0];
        else if (v < -lim) sat_acc = 8'(-lim);
        else               sat_acc = v[ACC_W-1:0];
    endfunction
endpackage

// File: rtl/msx_mouse_port_if.sv
// Bundle between the PS/2 mouse controller / joystick source and the MSX port A logic.
interface msx_mouse_port_if;
    logic       mouse_strobe;
    logic [8:0] mouse_dx;
    logic [8:0] mouse_dy;
    logic [1:0] mouse_btn;
    logic [5:0] joy_in;
    logic       msx_str;
    logic [5:0] port_out;
    logic       mouse_en;

    modport master (
        output mouse_strobe, mouse_dx, mouse_dy, mouse_btn, joy_in, msx_str,
        input  port_out, mouse_en
    );
    modport slave (
        input  mouse_strobe, mouse_dx, mouse_dy, mouse_btn, joy_in, msx_str,
        output port_out, mouse_en
    );
endinterface

// File: rtl/msx_mouse_acc.sv
// One-axis saturating movement accumulator with snapshot-and-clear.
// snap_nx is the snapshot as it will be after this cycle, so a P0 read sees the fresh value.
module msx_mouse_acc
    import msx_pkg::*;
#(
    parameter bit NEGATE = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               add,
    input  logic               clr,
    input  logic               snap,
    input  logic [DELTA_W-1:0] delta,
    output logic [ACC_W-1:0]   snap_nx
);
    logic [ACC_W-1:0] acc_q, acc_d, snap_q, snap_d, base;
    logic signed [9:0] base_x, delta_x;

    always_comb begin
        // Snapshot zeroes the base first, so a coincident add lands on an empty accumulator.
        base    = snap ? '0 : acc_q;
        base_x  = {{2{base[ACC_W-1]}}, base};
        delta_x = {delta[DELTA_W-1], delta};
        acc_d   = base;
        if (add) acc_d = sat_acc(base_x + delta_x);
        if (clr) acc_d = '0;
        snap_d = snap_q;
        if (snap) snap_d = NEGATE ? (~acc_q + 8'd1) : acc_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q  <= '0;
            snap_q <= '0;
        end else begin
            acc_q  <= acc_d;
            snap_q <= snap_d;
        end
    end

    assign snap_nx = snap_d;
endmodule

// File: rtl/msx_mouse_port.sv
// PS/2 mouse to MSX nibble-protocol converter on joystick port A, with joystick
// pass-through, strobe-driven phase machine and read timeout resynchronisation.
module msx_mouse_port
    import msx_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input logic            clk_sys,
    input logic            reset,
    msx_mouse_port_if.slave bus
);
    localparam int              TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES);

    mouse_phase_t     phase_q, phase_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             str_q, str_d;
    logic             mouse_en_q, mouse_en_d;
    logic [5:0]       port_out_q, port_out_d;
    logic             edge_det, clr, snap;
    logic [3:0]       nib;

    logic [NUM_AXES-1:0][DELTA_W-1:0] delta;
    logic [NUM_AXES-1:0][ACC_W-1:0]   snap_nx;

    assign delta    = {bus.mouse_dy, bus.mouse_dx};
    assign edge_det = bus.msx_str ^ str_q;
    assign clr      = (bus.joy_in != JOY_IDLE) && !bus.mouse_strobe;
    assign snap     = edge_det && mouse_en_q && (phase_q == P0);

    // Axis 0 is X, negated because MSX reports positive as left.
    for (genvar a = 0; a < NUM_AXES; a++) begin : g_axis
        msx_mouse_acc #(.NEGATE(a == 0)) u_acc (
            .clk    (clk_sys),
            .rst    (reset),
            .add    (bus.mouse_strobe),
            .clr    (clr),
            .snap   (snap),
            .delta  (delta[a]),
            .snap_nx(snap_nx[a])
        );
    end

    always_comb begin
        str_d      = bus.msx_str;
        mouse_en_d = mouse_en_q;
        phase_d    = phase_q;
        tmo_d      = tmo_q;

        if (bus.mouse_strobe)            mouse_en_d = 1'b1;
        else if (bus.joy_in != JOY_IDLE) mouse_en_d = 1'b0;

        if (clr) begin
            phase_d = P0;
            tmo_d   = '0;
        end else if (mouse_en_q && edge_det) begin
            phase_d = mouse_phase_t'(phase_q + 2'd1);
            tmo_d   = TMO_LOAD;
        end else if (tmo_q != '0) begin
            tmo_d = tmo_q - TMO_W'(1);
            if (tmo_q == TMO_W'(1)) phase_d = P0;
        end

        case (phase_q)
            P0:      nib = snap_nx[0][7:4];
            P1:      nib = snap_nx[0][3:0];
            P2:      nib = snap_nx[1][7:4];
            default: nib = snap_nx[1][3:0];
        endcase

        if (mouse_en_q) port_out_d = {~bus.mouse_btn, edge_det ? nib : port_out_q[3:0]};
        else            port_out_d = bus.joy_in;
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            phase_q    <= P0;
            tmo_q      <= '0;
            str_q      <= 1'b0;
            mouse_en_q <= 1'b0;
            port_out_q <= JOY_IDLE;
        end else begin
            phase_q    <= phase_d;
            tmo_q      <= tmo_d;
            str_q      <= str_d;
            mouse_en_q <= mouse_en_d;
            port_out_q <= port_out_d;
        end
    end

    assign bus.port_out = port_out_q;
    assign bus.mouse_en = mouse_en_q;
endmodule

// File: doc/msx_mouse_port.md
# msx_mouse_port

Converts PS/2 mouse packets (`mouse_strobe` plus signed deltas and buttons from the PS/2 mouse controller) into the MSX mouse nibble protocol on general-purpose joystick port A. It sits between the PS/2 mouse controller and the `emsx_top` joystick A input, and multiplexes the real joystick through when no mouse is in use. It accumulates movement between MSX reads, serialises it as four nibbles clocked by the PSG strobe line, and resynchronises after a read timeout.

## Interface
- `TIMEOUT_CYCLES`, default 100000: `clk_sys` cycles without a strobe edge before the nibble phase returns to 0.
- `clk_sys`  in  1  system clock (21.48 MHz domain), shared with `emsx_top`.
- `reset`  in  1  asynchronous, active-high.
- `mouse_strobe`  in  1  one-cycle pulse; a new PS/2 packet is valid.
- `mouse_dx`  in  9  signed two's-complement X delta; positive means right.
- `mouse_dy`  in  9  signed two's-complement Y delta; positive means up.
- `mouse_btn`  in  2  {right, left}, active-high.
- `joy_in`  in  6  joystick A, active-low; 6'h3F means idle.
- `msx_str`  in  1  port A strobe (pin 8) from `emsx_top`; synchronous to `clk_sys`.
- `port_out`  out  6  to `emsx_top` joystick A: [3:0] data, [5:4] buttons.
- `mouse_en`  out  1  high while mouse mode is active.

## Operation
- **Mode select**
  - `mouse_strobe` sets `mouse_en`.
  - `joy_in != 6'h3F` with no `mouse_strobe` in the same cycle clears it; `mouse_strobe` wins.
  - Clearing `mouse_en` forces phase 0, clears the timeout counter and clears both accumulators.
- **Joystick mode** (`mouse_en`=0): `port_out <= joy_in`.
- **Accumulators** (`acc_x`, `acc_y`, signed 8-bit):
  - On `mouse_strobe`, `acc += delta`.
  - The sum is computed at 10 bits and saturated to [-127, +127]; -128 is never produced.
- **Strobe edge**: `edge = msx_str ^ str_q`, where `str_q` is `msx_str` registered. `str_q` tracks in both modes, so enabling mouse mode never creates a false edge.
- **Phase machine**: 2-bit phase P0–P3. Each edge while `mouse_en`=1 does the following:
  - P0: snapshot `snap_x = -acc_x` (MSX convention: positive = left) and `snap_y = acc_y` (positive = up). Clear both accumulators. Drive `snap_x[7:4]`. Go to P1.
  - P1: drive `snap_x[3:0]`, go to P2.
  - P2: drive `snap_y[7:4]`, go to P3.
  - P3: drive `snap_y[3:0]`, go to P0.
- **Simultaneous P0 edge and `mouse_strobe`**: the snapshot takes the pre-cycle accumulator value, and the accumulator becomes the saturated new delta, so no movement is lost.
- **Timeout**
  - Each edge loads the counter with `TIMEOUT_CYCLES`.
  - When nonzero and there is no edge, it decrements. The transition 1→0 forces P0.
  - `port_out[3:0]` holds its last value.
- **Buttons**: `port_out[5:4] <= ~mouse_btn`, updated every cycle in mouse mode, independent of phase.

## Timing
- **Reset values**:
  - `port_out` = 6'h3F, `mouse_en` = 0, phase P0.
  - Accumulators, snapshots and timeout counter = 0.
  - `str_q` = 0.
- **Latency**:
  - A `msx_str` change sampled at edge n appears as a new nibble on `port_out` after edge n+1 (1 cycle). The MSX BIOS waits more than 20 µs between strobe and read.
  - `joy_in` to `port_out` in joystick mode: 1 cycle.
  - `mouse_strobe` to `mouse_en`: 1 cycle.
- **Back-to-back edges on consecutive cycles**: each one advances the phase; none is dropped.
- **Phase wrap**: P3 goes to P0 on an edge. An edge in the same cycle as timeout expiry takes the edge path; the reload wins.
- **Reset mid-sequence**: asynchronous return to all reset values; no partial packet survives.

## Structure
- Shared package `msx_pkg`:
  - `mouse_phase_t` enum (P0–P3).
  - `MOUSE_SAT = 127`.
  - Joystick idle constant `JOY_IDLE = 6'h3F`.
- One sub-module `msx_mouse_acc`: a saturating signed accumulator with add, clear and snapshot-and-clear. Instantiate it once per axis.
- All other logic (mode, phase, timeout, output mux) sits in the top module.

## Test plan
- **Reset**: assert `reset` mid-run, then release → `port_out`=6'h3F, `mouse_en`=0, and the first edge after mouse enable yields the X high nibble.
- **Basic packet**: strobe dx=+5, dy=-3, then toggle `msx_str` 4× → nibbles F, B, F, D (snap_x=-5=8'hFB, snap_y=8'hFD).
- **Saturation**: three strobes with dx=+100 → snap_x = -127 (8'h81), nibbles 8 then 1. Four strobes with dy=-200 → snap_y = -127 (8'h81).
- **Timeout**: two edges, wait `TIMEOUT_CYCLES`+2 cycles, then one edge → X high nibble of a fresh snapshot. Movement between reads is preserved in the accumulator.
- **Mode switching**: mouse active, then `joy_in`=6'h3E → `mouse_en`=0 next cycle, `port_out`=6'h3E the cycle after, and the accumulators are cleared. A later strobe returns to mouse mode.
- **Collision**: `mouse_strobe` with dx=+2 in the same cycle as the P0 edge, after accumulated dx=+4 → snap_x=-4 and `acc_x`=+2. The next sequence reads -2.
